clock_enable_sequencer: RTL

Sequences board start-up and recovery for the divided clock domains. It watches the MMCM `locked` signal and waits a settle interval after lock. It then enables the 100/50/25/12.5 MHz BUFGMUX gates one at a time, at fixed spacing. Finally it holds the processor/memIO reset until all clocks have run for a fixed time. It runs on the free-running 100 MHz MMCM output, sits beside the clock divider, and drives its gate selects plus the system reset.

---
 rtl/clock_enable_sequencer_if.sv | 53 +++++
 rtl/clock_enable_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_sequencer_if.sv
//==============================================================================
//  Module      : clock_enable_sequencer_if
//  Description : Signal bundle between the clock-enable sequencer and the
//                clock divider / system-reset fabric around it.
//
//  Signals:
//    locked           MMCM lock, asynchronous to the sequencer clock
//    clr_flag         synchronous request to clear lock_lost
//    clk_en[3:0]      BUFGMUX gate enables: [0]=100, [1]=50, [2]=25, [3]=12.5 MHz
//    sys_rst          active-high reset to the processor and memIO
//    ready            high only once the full start-up sequence has completed
//    lock_lost        sticky flag: lock dropped after settling began
//    lock_loss_count  saturating count of lock drops
//
//  Modports:
//    master  the sequencer (drives enables, reset and status)
//    slave   the surroundings (drive locked and clr_flag)
//
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface clock_enable_sequencer_if;
  logic       locked;
  logic       clr_flag;
  logic [3:0] clk_en;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_loss_count;

  modport master (
    input  locked,
    input  clr_flag,
    output clk_en,
    output sys_rst,
    output ready,
    output lock_lost,
    output lock_loss_count
  );

  modport slave (
    output locked,
    output clr_flag,
    input  clk_en,
    input  sys_rst,
    input  ready,
    input  lock_lost,
    input  lock_loss_count
  );
endinterface

`default_nettype wire

// File: rtl/clock_enable_sequencer.sv
//==============================================================================
//  Module      : clock_enable_sequencer
//  Description : Start-up / recovery sequencer for the divided clock domains.
//                Waits for MMCM lock, lets it settle, opens the 100/50/25/12.5
//                MHz gates one at a time at fixed spacing, then holds the
//                processor/memIO reset for a fixed time before declaring the
//                system ready. Any lock drop after settling began collapses the
//                sequence back to the start and is recorded.
//
//  Parameters:
//    SETTLE_LOG2  settle interval after lock = 2**SETTLE_LOG2 cycles
//    STAGE_GAP    cycles between successive clk_en bits (>= 1)
//    RST_HOLD     cycles sys_rst stays high after clk_en[3] rises (>= 1)
//
//  Ports:
//    clk    free-running 100 MHz reference (ungated MMCM output)
//    reset  asynchronous, active-low reset
//    bus    clock_enable_sequencer_if.master
//             in : locked, clr_flag
//             out: clk_en[3:0], sys_rst, ready, lock_lost, lock_loss_count[7:0]
//
//  All outputs are registered.
//
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module clock_enable_sequencer #(
  parameter int SETTLE_LOG2 = 2,
  parameter int STAGE_GAP   = 4,
  parameter int RST_HOLD    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  clock_enable_sequencer_if.master        bus
);

  //--------------------------------------------------------------------------
  // Interval counter sizing: one counter is shared by every timed phase, so it
  // must hold the longest terminal value; the extra bit keeps the terminal
  // compare unambiguous when the longest interval is an exact power of two.
  //--------------------------------------------------------------------------
  localparam int SETTLE_LEN = 1 << SETTLE_LOG2;
  localparam int MAX_SG     = (SETTLE_LEN > STAGE_GAP) ? SETTLE_LEN : STAGE_GAP;
  localparam int MAX_LEN    = (MAX_SG > RST_HOLD) ? MAX_SG : RST_HOLD;
  localparam int CNT_W      = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] c_cnt_zero    = '0;
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] c_stage_last  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] c_hold_last   = CNT_W'(RST_HOLD - 1);

  //--------------------------------------------------------------------------
  // State encoding
  //--------------------------------------------------------------------------
  localparam logic [2:0] c_st_wait_lock = 3'd0;
  localparam logic [2:0] c_st_settle    = 3'd1;
  localparam logic [2:0] c_st_stage     = 3'd2;
  localparam logic [2:0] c_st_hold_rst  = 3'd3;
  localparam logic [2:0] c_st_run       = 3'd4;

  //--------------------------------------------------------------------------
  // Registers
  //--------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_locked_s;
  logic [3:0]       r_clk_en;
  logic             r_sys_rst;
  logic             r_ready;
  logic             r_lock_lost;
  logic [7:0]       r_loss_count;

  //--------------------------------------------------------------------------
  // Next-state / next-output wires
  //--------------------------------------------------------------------------
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_clk_en_nxt;
  logic             w_sys_rst_nxt;
  logic             w_lock_lost_nxt;
  logic [7:0]       w_loss_count_nxt;

  logic w_active;
  logic w_loss;
  logic w_settle_done;
  logic w_stage_done;
  logic w_hold_done;

  // Once settling has begun, a low synchronized lock is a loss event. In
  // WAIT_LOCK a low lock merely keeps us waiting.
  assign w_active      = (r_state != c_st_wait_lock);
  assign w_loss        = w_active && !r_locked_s;
  assign w_settle_done = (r_state == c_st_settle)   && (r_cnt == c_settle_last);
  assign w_stage_done  = (r_state == c_st_stage)    && (r_cnt == c_stage_last);
  assign w_hold_done   = (r_state == c_st_hold_rst) && (r_cnt == c_hold_last);

  //--------------------------------------------------------------------------
  // Process 1: state and output registers, plus the lock synchronizer.
  // locked is asynchronous to clk, so it passes through two flops before the
  // FSM is allowed to look at it.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_st_wait_lock;
      r_cnt        <= c_cnt_zero;
      r_sync1      <= 1'b0;
      r_locked_s   <= 1'b0;
      r_clk_en     <= 4'b0000;
      r_sys_rst    <= 1'b1;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_loss_count <= 8'd0;
    end else begin
      r_sync1      <= bus.locked;
      r_locked_s   <= r_sync1;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_clk_en     <= w_clk_en_nxt;
      r_sys_rst    <= w_sys_rst_nxt;
      // ready is its own flop, loaded from the same source as sys_rst, so the
      // two can never disagree even for a cycle.
      r_ready      <= ~w_sys_rst_nxt;
      r_lock_lost  <= w_lock_lost_nxt;
      r_loss_count <= w_loss_count_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Process 2: next state and interval counter
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;

    if (w_loss) begin
      // Loss overrides whatever transition was due on this edge.
      w_state_nxt = c_st_wait_lock;
      w_cnt_nxt   = c_cnt_zero;
    end else begin
      case (r_state)
        c_st_wait_lock: begin
          if (r_locked_s) begin
            w_state_nxt = c_st_settle;
            w_cnt_nxt   = c_cnt_zero;
          end
        end

        c_st_settle: begin
          if (w_settle_done) begin
            w_state_nxt = c_st_stage;
            w_cnt_nxt   = c_cnt_zero;
          end else begin
            w_cnt_nxt   = r_cnt + c_cnt_one;
          end
        end

        c_st_stage: begin
          if (w_stage_done) begin
            w_cnt_nxt = c_cnt_zero;
            // clk_en[2] already set means this edge opens the last gate.
            if (r_clk_en[2]) begin
              w_state_nxt = c_st_hold_rst;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end

        c_st_hold_rst: begin
          if (w_hold_done) begin
            w_state_nxt = c_st_run;
            w_cnt_nxt   = c_cnt_zero;
          end else begin
            w_cnt_nxt   = r_cnt + c_cnt_one;
          end
        end

        c_st_run: begin
          w_state_nxt = c_st_run;
        end

        default: begin
          w_state_nxt = c_st_wait_lock;
          w_cnt_nxt   = c_cnt_zero;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Process 3: next values of the registered outputs
  //--------------------------------------------------------------------------
  always_comb begin
    w_clk_en_nxt     = r_clk_en;
    w_sys_rst_nxt    = r_sys_rst;
    w_lock_lost_nxt  = r_lock_lost;
    w_loss_count_nxt = r_loss_count;

    if (w_loss) begin
      w_clk_en_nxt    = 4'b0000;
      w_sys_rst_nxt   = 1'b1;
      // A clear requested on the same edge loses against the new loss.
      w_lock_lost_nxt = 1'b1;
      if (r_loss_count != 8'hFF) begin
        w_loss_count_nxt = r_loss_count + 8'd1;
      end
    end else begin
      if (bus.clr_flag) begin
        w_lock_lost_nxt = 1'b0;
      end
      if (w_settle_done) begin
        w_clk_en_nxt = 4'b0001;
      end
      // Shifting a one in from the bottom opens the gates strictly in order
      // 0 -> 3 and can never produce a gap.
      if (w_stage_done) begin
        w_clk_en_nxt = {r_clk_en[2:0], 1'b1};
      end
      if (w_hold_done) begin
        w_sys_rst_nxt = 1'b0;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign bus.clk_en          = r_clk_en;
  assign bus.sys_rst         = r_sys_rst;
  assign bus.ready           = r_ready;
  assign bus.lock_lost       = r_lock_lost;
  assign bus.lock_loss_count = r_loss_count;

  //--------------------------------------------------------------------------
  // Structural invariants of the sequence
  //--------------------------------------------------------------------------
  a_ready_is_not_rst : assert property (@(posedge clk) disable iff (!reset)
    r_ready == ~r_sys_rst);

  a_run_needs_all_clocks : assert property (@(posedge clk) disable iff (!reset)
    !r_sys_rst |-> (r_clk_en == 4'b1111));

  a_gates_in_order : assert property (@(posedge clk) disable iff (!reset)
    (r_clk_en == 4'b0000) || (r_clk_en == 4'b0001) || (r_clk_en == 4'b0011) ||
    (r_clk_en == 4'b0111) || (r_clk_en == 4'b1111));

endmodule

`default_nettype wire
